spr_bank: RTL and testbench
===========================

SPR_BANK -- requirements
Module: spr_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the bit width of each register entry.
REQ-002 SHALL have parameter DEPTH, default 32, the number of entries (power of two, at least 4).
REQ-003 SHALL have parameter NRD, default 2, the number of independent read ports.
REQ-004 SHALL derive the local constant AW = clog2(DEPTH) for address width.
REQ-005 SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, width 1: asynchronous active-low reset.
REQ-007 SHALL have port Sw, input, width 1: parallel-load strobe.
REQ-008 SHALL have port Sce, input, width DEPTH: per-entry select for parallel load.
REQ-009 SHALL have port Sdin_flat, input, width DEPTH*WIDTH: per-entry load data, entry i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port Sin, input, width WIDTH: shared load data, also the shift-in value.
REQ-011 SHALL have port Sshift, input, width 1: shift strobe.
REQ-012 SHALL have ports Swe (input, 1), Swa (input, AW) and Swd (input, WIDTH): single-entry write enable, address and data.
REQ-013 SHALL have port Sclr, input, width 1: start-clear pulse.
REQ-014 SHALL have ports Sre (input, NRD) and Sa_flat (input, NRD*AW): per-port read request and address, port p at [p*AW +: AW].
REQ-015 SHALL have ports Sout_flat (output, NRD*WIDTH) and Svalid (output, NRD): registered read data and per-port valid.
REQ-016 SHALL have port Sbusy, output, width 1: high while a clear sweep is in progress.

Function
REQ-017 SHALL apply exactly one update source per cycle, in priority order: clear sweep, then Sw, then Sshift, then Swe.
REQ-018 SHALL, on Sw, load every entry i with Sdin_flat chunk i where Sce[i]=1, and with Sin where Sce[i]=0.
REQ-019 SHALL, on Sshift, move entry i-1 into entry i for i=1..DEPTH-1, load Sin into entry 0, and discard entry DEPTH-1.
REQ-020 SHALL, on Swe, write Swd to entry Swa; other entries are unchanged.
REQ-021 SHALL implement read port p as follows: when Sre[p]=1, Sout_flat[p] takes entry Sa[p] at the next edge and Svalid[p]=1 for that cycle (1-cycle latency).
REQ-022 SHALL, when Sre[p]=0, hold Sout_flat[p] and drive Svalid[p]=0.
REQ-023 SHALL make a read and an update of the same entry in the same cycle return the pre-update value (read-before-write), on all ports independently.
REQ-024 SHALL implement the clear FSM with states IDLE and CLEAR.
REQ-025 SHALL, in IDLE, move to CLEAR on Sclr=1, with the counter at 0 and Sbusy=1 from the next cycle.
REQ-026 SHALL, in CLEAR, zero entry[counter] once per cycle and increment the counter; after writing entry DEPTH-1 it SHALL return to IDLE, with Sbusy=0 the following cycle (DEPTH cycles of Sbusy in total).
REQ-027 SHALL, in CLEAR, ignore Sclr and drop (not queue) any Sw, Sshift or Swe; reads remain serviced and return current contents.
REQ-028 SHALL wrap the counter only via return to IDLE, never past DEPTH-1.

Reset
REQ-029 SHALL, on rst_n low, immediately zero all entries, Sout_flat, Svalid, Sbusy and the counter, and set the FSM to IDLE, including mid-sweep.
REQ-030 SHALL ignore all strobes while rst_n is low; the first update takes effect on the first rising edge after deassertion.

Structure
REQ-031 SHALL place the shared package spr_pkg contents there: state enum (IDLE, CLEAR) and default WIDTH/DEPTH/NRD constants.
REQ-032 SHALL implement each read port as an instance of the sub-module spr_rdport (registered mux plus valid), replicated NRD times by generate.

Verification
REQ-033 SHALL verify parallel load: Sw=1, Sce=0x0000_0005, Sdin chunk0=0xA, chunk2=0xC, Sin=0x5 -> entries 0=0xA, 1=0x5, 2=0xC, 3..31=0x5.
REQ-034 SHALL verify shift: from entries i=i, Sshift=1 with Sin=0xFF for 1 cycle -> entry0=0xFF, entry1=0, entry31=30.
REQ-035 SHALL verify read-before-write: Swe to Swa=3 with Swd=0x1234 while port0 reads addr 3 (old 0x3) -> Sout0=0x3 with Svalid0=1; the next read returns 0x1234.
REQ-036 SHALL verify clear: Sclr pulse -> Sbusy high exactly 32 cycles; Swe issued mid-sweep is dropped; all entries read 0 afterwards.
REQ-037 SHALL verify reset mid-sweep: rst_n low at sweep cycle 10 -> Sbusy=0 and all entries 0 immediately; a subsequent Sclr starts a fresh 32-cycle sweep.
REQ-038 SHALL verify dual read: port0 reads addr 0 and port1 reads addr 31 in the same cycle -> both correct, both Svalid=1; Sre=0 the next cycle -> Svalid=0 with data held.

Source files
------------

// File: rtl/spr_pkg.sv
// Shared types and default sizing for the special-purpose register bank.
package spr_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefDepth = 32;
    localparam int unsigned DefNrd   = 2;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } clr_state_e;

endpackage

// File: rtl/spr_rdport.sv
// One registered read port: a mux over the flattened bank with a one-cycle valid strobe.
module spr_rdport #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   re_i,
    input  logic [AW-1:0]          addr_i,
    input  logic [DEPTH*WIDTH-1:0] mem_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   valid_o
);

    logic [WIDTH-1:0] rdata_d, rdata_q;
    logic             valid_q;

    // Data holds its last value when no read is requested.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_i[addr_i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            valid_q <= re_i;
        end
    end

    assign rdata_o = rdata_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/spr_bank.sv
// Register bank with parallel load, shift, single write, sweeping clear and NRD read ports.
module spr_bank
    import spr_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned NRD   = DefNrd,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   Sw,
    input  logic [DEPTH-1:0]       Sce,
    input  logic [DEPTH*WIDTH-1:0] Sdin_flat,
    input  logic [WIDTH-1:0]       Sin,
    input  logic                   Sshift,
    input  logic                   Swe,
    input  logic [AW-1:0]          Swa,
    input  logic [WIDTH-1:0]       Swd,
    input  logic                   Sclr,
    input  logic [NRD-1:0]         Sre,
    input  logic [NRD*AW-1:0]      Sa_flat,
    output logic [NRD*WIDTH-1:0]   Sout_flat,
    output logic [NRD-1:0]         Svalid,
    output logic                   Sbusy
);

    clr_state_e state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (Sclr) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                // Counter returns to zero through IDLE only; it never wraps on its own.
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
        endcase
    end

    // One update source per cycle; a running sweep drops all other strobes.
    always_comb begin
        mem_d = mem_q;
        if (state_q == StClear) begin
            mem_d[cnt_q] = '0;
        end else if (Sw) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_d[i] = Sce[i] ? Sdin_flat[i*WIDTH +: WIDTH] : Sin;
            end
        end else if (Sshift) begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                mem_d[i] = mem_q[i-1];
            end
            mem_d[0] = Sin;
        end else if (Swe) begin
            mem_d[Swa] = Swd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign Sbusy = (state_q == StClear);

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign mem_flat[g*WIDTH +: WIDTH] = mem_q[g];
    end

    // Ports read the registered contents, so same-cycle updates are not visible.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        spr_rdport #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH),
            .AW   (AW)
        ) u_rdport (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .re_i   (Sre[p]),
            .addr_i (Sa_flat[p*AW +: AW]),
            .mem_i  (mem_flat),
            .rdata_o(Sout_flat[p*WIDTH +: WIDTH]),
            .valid_o(Svalid[p])
        );
    end

endmodule

// File: tb/tb_spr_bank.sv
// Scoreboard bench for spr_bank: reads push expectations, a negedge monitor pops and compares.
module tb_spr_bank;

    localparam int W = 32;
    localparam int D = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             Sw;
    logic [D-1:0]     Sce;
    logic [D*W-1:0]   Sdin_flat;
    logic [W-1:0]     Sin;
    logic             Sshift;
    logic             Swe;
    logic [4:0]       Swa;
    logic [W-1:0]     Swd;
    logic             Sclr;
    logic [1:0]       Sre;
    logic [9:0]       Sa_flat;
    logic [2*W-1:0]   Sout_flat;
    logic [1:0]       Svalid;
    logic             Sbusy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] expq0 [$];
    logic [W-1:0] expq1 [$];
    logic [W-1:0] exp_mem [D];

    spr_bank dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Sw       (Sw),
        .Sce      (Sce),
        .Sdin_flat(Sdin_flat),
        .Sin      (Sin),
        .Sshift   (Sshift),
        .Swe      (Swe),
        .Swa      (Swa),
        .Swd      (Swd),
        .Sclr     (Sclr),
        .Sre      (Sre),
        .Sa_flat  (Sa_flat),
        .Sout_flat(Sout_flat),
        .Svalid   (Svalid),
        .Sbusy    (Sbusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every valid beat must match the oldest expectation for that port.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (Svalid[0]) begin
                if (expq0.size() == 0) check("port0 unexpected valid", 32'd1, 32'd0);
                else check("port0 read", Sout_flat[W-1:0], expq0.pop_front());
            end
            if (Svalid[1]) begin
                if (expq1.size() == 0) check("port1 unexpected valid", 32'd1, 32'd0);
                else check("port1 read", Sout_flat[2*W-1:W], expq1.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd2(input logic [4:0] a0, input logic [W-1:0] e0, input bit use1,
                       input logic [4:0] a1, input logic [W-1:0] e1);
        Sre     = {use1, 1'b1};
        Sa_flat = {a1, a0};
        expq0.push_back(e0);
        if (use1) expq1.push_back(e1);
        tick();
        Sre = 2'b00;
    endtask

    // Reads the whole bank two entries per cycle against exp_mem.
    task automatic read_all();
        for (int i = 0; i < D; i += 2) begin
            rd2(5'(i), exp_mem[i], 1'b1, 5'(i + 1), exp_mem[i+1]);
        end
        tick();
    endtask

    // Loads entry i with base+i through a full-select parallel load.
    task automatic load_index(input logic [W-1:0] base);
        Sce = '1;
        for (int i = 0; i < D; i++) begin
            Sdin_flat[i*W +: W] = base + W'(i);
            exp_mem[i] = base + W'(i);
        end
        Sw = 1'b1;
        tick();
        Sw  = 1'b0;
        Sce = '0;
    endtask

    task automatic count_sweep(input string name, input bit poke);
        int busy_cycles;
        busy_cycles = 0;
        while (Sbusy === 1'b1 && busy_cycles < 100) begin
            Swe = poke && (busy_cycles == 5);
            Swa = 5'd0;
            Swd = 32'hDEAD_BEEF;
            busy_cycles++;
            tick();
        end
        Swe = 1'b0;
        check(name, W'(busy_cycles), 32'd32);
    endtask

    initial begin
        rst_n = 1'b0; Sw = 0; Sce = '0; Sdin_flat = '0; Sin = '0; Sshift = 0;
        Swe = 0; Swa = '0; Swd = '0; Sclr = 0; Sre = '0; Sa_flat = '0;
        #3;
        check("reset Sbusy", W'(Sbusy), 32'd0);
        check("reset Svalid", W'(Svalid), 32'd0);
        check("reset Sout0", Sout_flat[W-1:0], 32'd0);
        check("reset Sout1", Sout_flat[2*W-1:W], 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Parallel load with partial select.
        Sce = 32'h0000_0005;
        Sdin_flat[0*W +: W] = 32'hA;
        Sdin_flat[2*W +: W] = 32'hC;
        Sin = 32'h5;
        Sw  = 1'b1;
        tick();
        Sw = 1'b0; Sce = '0;
        for (int i = 0; i < D; i++) exp_mem[i] = 32'h5;
        exp_mem[0] = 32'hA;
        exp_mem[2] = 32'hC;
        read_all();

        // Shift from entries i=i.
        load_index(32'd0);
        Sin = 32'hFF; Sshift = 1'b1;
        tick();
        Sshift = 1'b0;
        for (int i = D - 1; i > 0; i--) exp_mem[i] = exp_mem[i-1];
        exp_mem[0] = 32'hFF;
        read_all();

        // Read-before-write on entry 3.
        load_index(32'd0);
        Swe = 1'b1; Swa = 5'd3; Swd = 32'h1234;
        rd2(5'd3, 32'h3, 1'b0, 5'd0, 32'h0);
        Swe = 1'b0;
        rd2(5'd3, 32'h1234, 1'b0, 5'd0, 32'h0);
        exp_mem[3] = 32'h1234;

        // Dual read then hold.
        rd2(5'd0, 32'h0, 1'b1, 5'd31, 32'd31);
        tick();
        check("hold Svalid", W'(Svalid), 32'd0);
        check("hold Sout0", Sout_flat[W-1:0], 32'd0);
        check("hold Sout1", Sout_flat[2*W-1:W], 32'd31);

        // Clear sweep with a dropped write mid-sweep.
        Sclr = 1'b1;
        tick();
        Sclr = 1'b0;
        check("busy after Sclr", W'(Sbusy), 32'd1);
        count_sweep("sweep length", 1'b1);
        for (int i = 0; i < D; i++) exp_mem[i] = '0;
        read_all();

        // Reset mid-sweep, with a write held during reset.
        load_index(32'd100);
        Sclr = 1'b1;
        tick();
        Sclr = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("mid-sweep reset Sbusy", W'(Sbusy), 32'd0);
        check("mid-sweep reset Svalid", W'(Svalid), 32'd0);
        check("mid-sweep reset Sout0", Sout_flat[W-1:0], 32'd0);
        Swe = 1'b1; Swa = 5'd20; Swd = 32'h77;
        tick();
        Swe = 1'b0;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < D; i++) exp_mem[i] = '0;
        read_all();

        // Fresh sweep after reset.
        Sclr = 1'b1;
        tick();
        Sclr = 1'b0;
        count_sweep("fresh sweep length", 1'b0);

        tick();
        check("port0 reads outstanding", W'(expq0.size()), 32'd0);
        check("port1 reads outstanding", W'(expq1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
